sat_accum: RTL and testbench

Pipelined 16-bit saturating accumulator that sits directly downstream of the team's `cla_16bit` saturating adder/subtractor and consumes its sum and overflow outputs. It accepts a stream of ADD/SUB/LOAD/CLR commands over a valid/ready handshake and keeps a running accumulator. For every accepted command it returns exactly one result beat carrying the accumulator value and N/Z/V flags, with backpressure. The execute and reduction paths use it for multi-operand sums.

---
 rtl/sat_accum.sv | 193 +++++++++++++++++++
 tb/tb_sat_accum.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sat_accum.sv
// Two-stage saturating accumulator with valid/ready on both sides, built around
// a 16-bit carry-lookahead saturating adder/subtractor (cla_16bit).

module cla_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        ovfl
);

  logic [15:0] b_eff;
  logic [15:0] p;
  logic [15:0] g;
  logic [15:0] c;
  logic [15:0] raw;
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  logic [2:0]  grp_c;
  logic [3:0]  grp_cin;
  logic        c_out;

  function automatic logic [2:0] lookahead3(input logic [2:0] gi, input logic [2:0] pi,
                                            input logic c0);
    logic [2:0] cc;
    cc[0] = gi[0] | (pi[0] & c0);
    cc[1] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & c0);
    cc[2] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0]) | (pi[2] & pi[1] & pi[0] & c0);
    return cc;
  endfunction

  function automatic logic carry_out4(input logic [3:0] gi, input logic [3:0] pi,
                                      input logic c0);
    return gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1]) |
           (pi[3] & pi[2] & pi[1] & gi[0]) | (&pi & c0);
  endfunction

  // Subtraction is a + ~b + 1, so cin doubles as the operand-invert select.
  assign b_eff = b ^ {16{cin}};
  assign p     = a ^ b_eff;
  assign g     = a & b_eff;

  genvar k;
  generate
    for (k = 0; k < 4; k++) begin : g_grp
      assign grp_g[k] = carry_out4(g[4*k +: 4], p[4*k +: 4], 1'b0);
      assign grp_p[k] = &p[4*k +: 4];
      assign c[4*k]   = grp_cin[k];
      assign c[4*k+1 +: 3] = lookahead3(g[4*k +: 3], p[4*k +: 3], grp_cin[k]);
    end
  endgenerate

  assign grp_c   = lookahead3(grp_g[2:0], grp_p[2:0], cin);
  assign grp_cin = {grp_c, cin};
  assign c_out   = carry_out4(grp_g, grp_p, cin);

  // On overflow both operands share a sign, and that sign is the true result sign.
  assign raw  = p ^ c;
  assign ovfl = c_out ^ c[15];
  assign sum  = ovfl ? (a[15] ? 16'h8000 : 16'h7FFF) : raw;

endmodule

module sat_accum (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_acc,
  output logic        out_n,
  output logic        out_z,
  output logic        out_v,
  output logic        sticky_v
);

  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_LOAD = 2'b10, OP_CLR = 2'b11} op_e;

  logic        e_valid_q, e_valid_d;
  op_e         e_op_q, e_op_d;
  logic [15:0] e_data_q, e_data_d;
  logic [15:0] acc_q, acc_d;
  logic        out_valid_q, out_valid_d;
  logic        out_n_q, out_n_d;
  logic        out_z_q, out_z_d;
  logic        out_v_q, out_v_d;
  logic        sticky_v_q, sticky_v_d;

  logic        advance;
  logic        in_fire;
  logic        e_fire;
  logic [15:0] cla_sum;
  logic        cla_ovfl;
  logic [15:0] result;
  logic        result_v;

  assign advance  = ~out_valid_q | out_ready;
  assign in_ready = ~e_valid_q | advance;
  assign in_fire  = in_valid & in_ready;
  assign e_fire   = e_valid_q & advance;

  cla_16bit u_cla (
    .a    (acc_q),
    .b    (e_data_q),
    .cin  (e_op_q == OP_SUB),
    .sum  (cla_sum),
    .ovfl (cla_ovfl)
  );

  always_comb begin
    result   = 16'h0000;
    result_v = 1'b0;
    case (e_op_q)
      OP_ADD, OP_SUB: begin
        result   = cla_sum;
        result_v = cla_ovfl;
      end
      OP_LOAD: result = e_data_q;
      default: result = 16'h0000;
    endcase
  end

  // The output register doubles as the accumulator, so out_acc is frozen
  // exactly when E is stalled.
  always_comb begin
    e_valid_d   = e_valid_q;
    e_op_d      = e_op_q;
    e_data_d    = e_data_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_n_d     = out_n_q;
    out_z_d     = out_z_q;
    out_v_d     = out_v_q;
    sticky_v_d  = sticky_v_q;

    if (in_fire) begin
      e_valid_d = 1'b1;
      e_op_d    = op_e'(in_op);
      e_data_d  = in_data;
    end else if (e_fire) begin
      e_valid_d = 1'b0;
    end

    if (e_fire) begin
      acc_d       = result;
      out_valid_d = 1'b1;
      out_n_d     = result[15];
      out_z_d     = (result == 16'h0000);
      out_v_d     = result_v;
      if (result_v)
        sticky_v_d = 1'b1;
      else if (e_op_q == OP_CLR)
        sticky_v_d = 1'b0;
    end else if (out_valid_q & out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_valid_q   <= 1'b0;
      e_op_q      <= OP_ADD;
      e_data_q    <= 16'h0000;
      acc_q       <= 16'h0000;
      out_valid_q <= 1'b0;
      out_n_q     <= 1'b0;
      out_z_q     <= 1'b0;
      out_v_q     <= 1'b0;
      sticky_v_q  <= 1'b0;
    end else begin
      e_valid_q   <= e_valid_d;
      e_op_q      <= e_op_d;
      e_data_q    <= e_data_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_n_q     <= out_n_d;
      out_z_q     <= out_z_d;
      out_v_q     <= out_v_d;
      sticky_v_q  <= sticky_v_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_acc   = acc_q;
  assign out_n     = out_n_q;
  assign out_z     = out_z_q;
  assign out_v     = out_v_q;
  assign sticky_v  = sticky_v_q;

endmodule

// File: tb/tb_sat_accum.sv
// Self-checking bench for sat_accum: directed scenarios plus randomized
// handshake traffic scored against an integer-arithmetic reference model.

module tb_sat_accum;

  typedef struct {
    logic [15:0] acc;
    logic        n;
    logic        z;
    logic        v;
    logic        s;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [15:0] in_data = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_acc;
  logic        out_n, out_z, out_v, sticky_v;

  int    checks = 0;
  int    failures = 0;
  int    acceptCount = 0;
  int    beatCount = 0;
  logic  lastAccepted = 1'b0;
  int    modelAcc = 0;
  logic  modelSticky = 1'b0;
  beat_t expQ[$];

  sat_accum dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_n     (out_n),
    .out_z     (out_z),
    .out_v     (out_v),
    .sticky_v  (sticky_v)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer arithmetic, then clamp to the 16-bit signed range.
  function automatic beat_t modelStep(input logic [1:0] op, input logic [15:0] data);
    beat_t b;
    int r;
    int d;
    d = int'($signed(data));
    case (op)
      2'b00:   r = modelAcc + d;
      2'b01:   r = modelAcc - d;
      2'b10:   r = d;
      default: r = 0;
    endcase
    b.v = 1'b0;
    if (r > 32767) begin r = 32767; b.v = 1'b1; end
    if (r < -32768) begin r = -32768; b.v = 1'b1; end
    modelAcc = r;
    if (b.v) modelSticky = 1'b1;
    if (op == 2'b11) modelSticky = 1'b0;
    b.acc = r[15:0];
    b.n   = (r < 0);
    b.z   = (r == 0);
    b.s   = modelSticky;
    return b;
  endfunction

  // One clock: observe handshakes mid-cycle, score beats, advance the model.
  task automatic tick();
    beat_t e;
    @(negedge clk);
    lastAccepted = 1'b0;
    if (rst) begin
      expQ.delete();
      modelAcc = 0;
      modelSticky = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        beatCount++;
        if (expQ.size() == 0) begin
          checkOutput("spurious_beat", 32'd1, 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("acc", {16'h0, out_acc}, {16'h0, e.acc});
          checkOutput("flag_n", {31'h0, out_n}, {31'h0, e.n});
          checkOutput("flag_z", {31'h0, out_z}, {31'h0, e.z});
          checkOutput("flag_v", {31'h0, out_v}, {31'h0, e.v});
          checkOutput("sticky", {31'h0, sticky_v}, {31'h0, e.s});
        end
      end
      if (in_valid && in_ready) begin
        lastAccepted = 1'b1;
        acceptCount++;
        expQ.push_back(modelStep(in_op, in_data));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [15:0] data);
    int n;
    in_valid = 1'b1;
    in_op    = op;
    in_data  = data;
    n = 0;
    do begin
      tick();
      n++;
    end while (!lastAccepted && n < 50);
    if (!lastAccepted) checkOutput("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((expQ.size() != 0 || out_valid) && n < 20) begin
      tick();
      n++;
    end
    checkOutput("drain_left", expQ.size(), 32'd0);
  endtask

  initial begin
    logic [15:0] frozen;
    int cyc;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_out_valid", {31'h0, out_valid}, 32'd0);
    checkOutput("rst_out_acc", {16'h0, out_acc}, 32'h0);
    checkOutput("rst_flags", {28'h0, out_n, out_z, out_v, sticky_v}, 32'h0);
    checkOutput("rst_in_ready", {31'h0, in_ready}, 32'd1);

    // Back-to-back ADD/ADD/SUB with latency probe on the first command.
    applyStimulus(2'b00, 16'd5);
    checkOutput("lat_k1_valid", {31'h0, out_valid}, 32'd0);
    applyStimulus(2'b00, 16'd7);
    checkOutput("lat_k2_valid", {31'h0, out_valid}, 32'd1);
    checkOutput("lat_k2_acc", {16'h0, out_acc}, 32'd5);
    applyStimulus(2'b01, 16'd2);
    drain();
    checkOutput("seq_final", {16'h0, out_acc}, 32'd10);

    applyStimulus(2'b10, 16'h7FF0);
    applyStimulus(2'b00, 16'h0020);
    drain();
    checkOutput("pos_sat", {16'h0, out_acc}, 32'h7FFF);
    checkOutput("pos_sat_sticky", {31'h0, sticky_v}, 32'd1);
    applyStimulus(2'b11, 16'h1234);
    drain();
    checkOutput("clr_acc", {16'h0, out_acc}, 32'h0);
    checkOutput("clr_sticky", {30'h0, out_z, sticky_v}, 32'b10);

    applyStimulus(2'b10, 16'h0000);
    applyStimulus(2'b01, 16'h8000);
    applyStimulus(2'b10, 16'h8000);
    applyStimulus(2'b00, 16'h8000);
    applyStimulus(2'b10, 16'h7FFF);
    applyStimulus(2'b00, 16'h0000);
    drain();
    checkOutput("max_plus_zero", {16'h0, out_acc}, 32'h7FFF);

    // Backpressure: two accepts fill the pipe, output frozen until release.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = 2'b10;
    in_data   = 16'd100;
    tick();
    in_op   = 2'b00;
    in_data = 16'd1;
    tick();
    checkOutput("bp_full", {31'h0, in_ready}, 32'd0);
    frozen = out_acc;
    in_data = 16'd2;
    repeat (3) tick();
    checkOutput("bp_frozen", {16'h0, out_acc}, {16'h0, frozen});
    checkOutput("bp_accepts", {31'h0, in_ready}, 32'd0);
    out_ready = 1'b1;
    applyStimulus(2'b00, 16'd2);
    applyStimulus(2'b01, 16'd3);
    drain();
    checkOutput("bp_final", {16'h0, out_acc}, 32'd100);

    // Randomized traffic on both handshakes.
    acceptCount = 0;
    beatCount   = 0;
    in_valid    = 1'b0;
    cyc = 0;
    while (acceptCount < 1000 && cyc < 20000) begin
      int r;
      if (!in_valid || lastAccepted) begin
        in_valid = ($urandom_range(0, 3) != 0);
        r = $urandom_range(0, 9);
        in_op = (r < 4) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
        case ($urandom_range(0, 3))
          0:       in_data = 16'h8000;
          1:       in_data = 16'h7FFF;
          default: in_data = 16'($urandom);
        endcase
      end
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    drain();
    checkOutput("rand_accepts", acceptCount, 32'd1000);
    checkOutput("rand_beats", beatCount, acceptCount);

    // Reset with two commands in flight; a command held during reset is dropped.
    out_ready = 1'b0;
    applyStimulus(2'b10, 16'd50);
    applyStimulus(2'b00, 16'd9);
    in_valid = 1'b1;
    in_op    = 2'b00;
    in_data  = 16'd77;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    checkOutput("midrst_valid", {31'h0, out_valid}, 32'd0);
    checkOutput("midrst_acc", {16'h0, out_acc}, 32'd0);
    checkOutput("midrst_in_ready", {31'h0, in_ready}, 32'd1);
    out_ready = 1'b1;
    tick();
    checkOutput("midrst_no_beat", {31'h0, out_valid}, 32'd0);
    applyStimulus(2'b00, 16'd3);
    drain();
    checkOutput("post_rst_add", {16'h0, out_acc}, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
